// File: rtl/tx_sched_pkg.sv
// Shared types and default timing for the backscatter MAC transmit scheduler.
//   state_t      : scheduler FSM states
//   DELAY_CYC    : default settling delay, excitation detect to header start
//   HEAD_CYC     : default header phase length
//   GAP_CYC      : default inter-packet gap
//   CTR_W        : width of the shared phase down-counter
package tx_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELAY = 3'd1,
        HEAD  = 3'd2,
        DATA  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam int DELAY_CYC = 40;
    localparam int HEAD_CYC  = 1920;
    localparam int GAP_CYC   = 500;
    localparam int CTR_W     = 12;

endpackage

// File: rtl/tx_scheduler_sig_sync.sv
// Two-flop synchronizer with a history flop for rising-edge detection.
// Reusable for any asynchronous level input.
//   clock    in  : destination clock
//   reset    in  : asynchronous active-low reset, clears all flops
//   async_in in  : asynchronous level input
//   sync_out out : synchronized level (second flop)
//   rise     out : one-cycle pulse when the synchronized level goes 0 -> 1
module sig_sync (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = async_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign sync_out = s2_q;
    assign rise     = s2_q & ~s3_q;

endmodule

// File: rtl/tx_scheduler.sv
// Packet-level sequencer for the backscatter MAC transmitter. Waits a
// settling delay after excitation appears, then commands the MAC through
// header and data phases, enforces an inter-packet gap and counts
// completed and aborted packets.
//   clock      in  : system clock (10 MHz)
//   reset      in  : asynchronous active-low reset
//   insig      in  : excitation present, asynchronous
//   enable     in  : scheduler enable, only looked at in IDLE
//   pkt_len    in  : data phase length in cycles, captured on HEAD entry
//   mac_start  out : one-cycle pulse on the first HEAD cycle
//   sending    out : HEAD or DATA
//   head       out : HEAD phase command
//   datacmd    out : DATA phase command
//   busy       out : not IDLE
//   abort      out : one-cycle pulse when excitation is lost in HEAD/DATA
//   pkt_cnt    out : completed packets, wrapping
//   abort_cnt  out : aborted packets, wrapping
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a fresh excitation rise with enable set
// DELAY | excitation settling; loss of excitation returns to IDLE quietly
// HEAD  | preamble/PLCP header; loss of excitation aborts
// DATA  | payload for the latched length; loss of excitation aborts
// GAP   | mandatory inter-packet gap, rises ignored
module tx_scheduler #(
    parameter int DELAY_CYC = tx_sched_pkg::DELAY_CYC,
    parameter int HEAD_CYC  = tx_sched_pkg::HEAD_CYC,
    parameter int GAP_CYC   = tx_sched_pkg::GAP_CYC,
    parameter int LEN_W     = 12,
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             insig,
    input  logic             enable,
    input  logic [LEN_W-1:0] pkt_len,
    output logic             mac_start,
    output logic             sending,
    output logic             head,
    output logic             datacmd,
    output logic             busy,
    output logic             abort,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] abort_cnt
);

    import tx_sched_pkg::*;

    localparam logic [CTR_W-1:0] DELAY_LOAD = CTR_W'(DELAY_CYC - 1);
    localparam logic [CTR_W-1:0] HEAD_LOAD  = CTR_W'(HEAD_CYC - 1);
    localparam logic [CTR_W-1:0] GAP_LOAD   = CTR_W'(GAP_CYC - 1);

    logic ins;
    logic rise;

    sig_sync u_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (insig),
        .sync_out (ins),
        .rise     (rise)
    );

    state_t             state_q, state_d;
    logic [CTR_W-1:0]   ctr_q, ctr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]   abort_cnt_q, abort_cnt_d;
    logic               abort_q, abort_d;
    logic               mac_start_q, mac_start_d;
    logic               sending_q, sending_d;
    logic               head_q, head_d;
    logic               datacmd_q, datacmd_d;
    logic               busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        len_d       = len_q;
        pkt_cnt_d   = pkt_cnt_q;
        abort_cnt_d = abort_cnt_q;
        abort_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // Only an edge starts a packet, so a held-high excitation
                // cannot retrigger after the gap.
                if (rise && enable) begin
                    state_d = DELAY;
                    ctr_d   = DELAY_LOAD;
                end
            end
            DELAY: begin
                if (!ins) begin
                    state_d = IDLE;
                end else if (ctr_q == '0) begin
                    state_d = HEAD;
                    ctr_d   = HEAD_LOAD;
                    len_d   = pkt_len;
                end else begin
                    ctr_d = ctr_q - CTR_W'(1);
                end
            end
            HEAD: begin
                // Loss of excitation wins over a coincident phase end.
                if (!ins) begin
                    state_d     = GAP;
                    ctr_d       = GAP_LOAD;
                    abort_d     = 1'b1;
                    abort_cnt_d = abort_cnt_q + CNT_W'(1);
                end else if (ctr_q == '0) begin
                    if (len_q != '0) begin
                        state_d = DATA;
                        ctr_d   = CTR_W'(len_q - LEN_W'(1));
                    end else begin
                        state_d   = GAP;
                        ctr_d     = GAP_LOAD;
                        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                    end
                end else begin
                    ctr_d = ctr_q - CTR_W'(1);
                end
            end
            DATA: begin
                if (!ins) begin
                    state_d     = GAP;
                    ctr_d       = GAP_LOAD;
                    abort_d     = 1'b1;
                    abort_cnt_d = abort_cnt_q + CNT_W'(1);
                end else if (ctr_q == '0) begin
                    state_d   = GAP;
                    ctr_d     = GAP_LOAD;
                    pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                end else begin
                    ctr_d = ctr_q - CTR_W'(1);
                end
            end
            GAP: begin
                if (ctr_q == '0) begin
                    state_d = IDLE;
                end else begin
                    ctr_d = ctr_q - CTR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ctr_d   = '0;
            end
        endcase

        // Phase outputs are registered copies decoded from the next state,
        // so they line up exactly with the state register.
        mac_start_d = (state_d == HEAD) && (state_q != HEAD);
        head_d      = (state_d == HEAD);
        datacmd_d   = (state_d == DATA);
        sending_d   = (state_d == HEAD) || (state_d == DATA);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ctr_q       <= '0;
            len_q       <= '0;
            pkt_cnt_q   <= '0;
            abort_cnt_q <= '0;
            abort_q     <= 1'b0;
            mac_start_q <= 1'b0;
            sending_q   <= 1'b0;
            head_q      <= 1'b0;
            datacmd_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            len_q       <= len_d;
            pkt_cnt_q   <= pkt_cnt_d;
            abort_cnt_q <= abort_cnt_d;
            abort_q     <= abort_d;
            mac_start_q <= mac_start_d;
            sending_q   <= sending_d;
            head_q      <= head_d;
            datacmd_q   <= datacmd_d;
            busy_q      <= busy_d;
        end
    end

    assign mac_start = mac_start_q;
    assign sending   = sending_q;
    assign head      = head_q;
    assign datacmd   = datacmd_q;
    assign busy      = busy_q;
    assign abort     = abort_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign abort_cnt = abort_cnt_q;

endmodule

// File: tb/tb_tx_scheduler.sv
module tb_tx_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        insig;
    logic        enable;
    logic [11:0] pkt_len;
    logic        mac_start, sending, head, datacmd, busy, abort;
    logic [15:0] pkt_cnt, abort_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;
    int t0      = 0;

    tx_scheduler dut (
        .clock     (clock),
        .reset     (reset),
        .insig     (insig),
        .enable    (enable),
        .pkt_len   (pkt_len),
        .mac_start (mac_start),
        .sending   (sending),
        .head      (head),
        .datacmd   (datacmd),
        .busy      (busy),
        .abort     (abort),
        .pkt_cnt   (pkt_cnt),
        .abort_cnt (abort_cnt)
    );

    always #50 clock = ~clock;

    always @(posedge clock) edge_n++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Edge 0 is the first rising edge after mark(); upto(e) returns 1 time
    // unit after edge e.
    task automatic mark();
        t0 = edge_n;
    endtask

    task automatic upto(input int e);
        while (edge_n < t0 + e + 1) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        reset   = 1'b0;
        insig   = 1'b0;
        enable  = 1'b0;
        pkt_len = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_outs", {27'd0, sending, head, datacmd, mac_start, abort}, 32'd0);
        chk("rst_cnts", {pkt_cnt, abort_cnt}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // nominal packet, length 100
        enable  = 1'b1;
        pkt_len = 12'd100;
        insig   = 1'b1;
        mark();
        upto(1);    chk("nom_idle_e1", {31'd0, busy}, 32'd0);
        upto(2);    chk("nom_delay_e2", {30'd0, busy, head}, 32'b10);
        upto(41);   chk("nom_nohead_e41", {31'd0, head}, 32'd0);
        upto(42);   chk("nom_head_e42", {29'd0, head, sending, mac_start}, 32'b111);
        upto(43);   chk("nom_head_e43", {30'd0, head, mac_start}, 32'b10);
        upto(1961); chk("nom_head_e1961", {30'd0, head, datacmd}, 32'b10);
        upto(1962); chk("nom_data_e1962", {29'd0, head, datacmd, sending}, 32'b011);
        upto(2061); chk("nom_data_e2061", {15'd0, datacmd, pkt_cnt}, {15'd0, 1'b1, 16'd0});
        upto(2062); chk("nom_gap_e2062", {28'd0, datacmd, sending, busy, abort}, 32'b0010);
                    chk("nom_pkt_cnt", {pkt_cnt, abort_cnt}, {16'd1, 16'd0});
        upto(2561); chk("nom_gap_e2561", {31'd0, busy}, 32'd1);
        upto(2562); chk("nom_idle_e2562", {31'd0, busy}, 32'd0);
        upto(2620); chk("nom_held_high", {15'd0, busy, pkt_cnt}, {15'd0, 1'b0, 16'd1});

        // zero length, with a sub-cycle glitch in HEAD and a re-rise in GAP
        insig = 1'b0;
        upto(2625);
        pkt_len = 12'd0;
        insig   = 1'b1;
        mark();
        upto(42);   chk("zl_head_e42", {30'd0, head, mac_start}, 32'b11);
        upto(100);
        insig = 1'b0;
        #20;
        insig = 1'b1;
        upto(101);  chk("zl_glitch", {29'd0, head, mac_start, busy}, 32'b101);
        upto(1961); chk("zl_head_e1961", {31'd0, head}, 32'd1);
        upto(1962); chk("zl_gap_e1962", {28'd0, head, datacmd, sending, busy}, 32'b0001);
                    chk("zl_cnts", {pkt_cnt, abort_cnt}, {16'd2, 16'd0});
        upto(2000);
        insig = 1'b0;
        upto(2005);
        insig = 1'b1;
        upto(2010); chk("zl_gap_rerise", {30'd0, busy, head}, 32'b10);
        upto(2461); chk("zl_gap_e2461", {31'd0, busy}, 32'd1);
        upto(2462); chk("zl_idle_e2462", {31'd0, busy}, 32'd0);
        upto(2500); chk("zl_no_retrig", {15'd0, busy, pkt_cnt}, {15'd0, 1'b0, 16'd2});

        // abort at DATA cycle 30
        insig = 1'b0;
        upto(2505);
        pkt_len = 12'd100;
        insig   = 1'b1;
        mark();
        upto(1962); chk("ab_data_e1962", {31'd0, datacmd}, 32'd1);
        upto(1991);
        insig = 1'b0;
        upto(1992); chk("ab_e1992", {31'd0, sending}, 32'd1);
        upto(1993); chk("ab_e1993", {29'd0, sending, datacmd, abort}, 32'b110);
        upto(1994); chk("ab_e1994", {28'd0, sending, datacmd, busy, abort}, 32'b0011);
                    chk("ab_cnts", {pkt_cnt, abort_cnt}, {16'd2, 16'd1});
        upto(1995); chk("ab_pulse_end", {31'd0, abort}, 32'd0);
        upto(2493); chk("ab_gap_e2493", {31'd0, busy}, 32'd1);
        upto(2494); chk("ab_idle_e2494", {31'd0, busy}, 32'd0);

        // excitation lost during DELAY
        upto(2500);
        pkt_len = 12'd7;
        insig   = 1'b1;
        mark();
        upto(2);    chk("dl_delay_e2", {31'd0, busy}, 32'd1);
        upto(9);
        insig = 1'b0;
        upto(11);   chk("dl_delay_e11", {31'd0, busy}, 32'd1);
        upto(12);   chk("dl_idle_e12", {31'd0, busy}, 32'd0);
        upto(60);   chk("dl_nohead", {30'd0, head, busy}, 32'b00);
                    chk("dl_cnts", {pkt_cnt, abort_cnt}, {16'd2, 16'd1});

        // rise while disabled, then enable with insig held
        enable = 1'b0;
        insig  = 1'b1;
        mark();
        upto(50);   chk("en0_no_pkt", {31'd0, busy}, 32'd0);
        enable = 1'b1;
        upto(60);   chk("en1_held_no_pkt", {31'd0, busy}, 32'd0);
        insig = 1'b0;
        upto(65);

        // asynchronous reset in HEAD, then a short packet
        pkt_len = 12'd5;
        insig   = 1'b1;
        mark();
        upto(100);  chk("ar_head_e100", {31'd0, head}, 32'd1);
        #10;
        reset = 1'b0;
        #1;
        chk("ar_outs", {26'd0, busy, sending, head, datacmd, mac_start, abort}, 32'd0);
        chk("ar_cnts", {pkt_cnt, abort_cnt}, 32'd0);
        insig = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        mark();
        upto(3);
        insig = 1'b1;
        mark();
        upto(42);   chk("ar_head_e42", {30'd0, head, mac_start}, 32'b11);
        upto(1962); chk("ar_data_e1962", {31'd0, datacmd}, 32'd1);
        upto(1966); chk("ar_data_e1966", {31'd0, datacmd}, 32'd1);
        upto(1967); chk("ar_gap_e1967", {30'd0, datacmd, sending}, 32'b00);
                    chk("ar_cnts_after", {pkt_cnt, abort_cnt}, {16'd1, 16'd0});
        upto(2467); chk("ar_idle_e2467", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
